div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle iterative integer divider for the execute stage, the next step after the multi-cycle multiply-accumulate path. It takes operands from `ex` and produces a `{remainder, quotient}` pair after WIDTH+2 cycles, one restoring-division step per cycle. While a divide is in flight, `ex` raises `stallreq` from `ready_o` so the pipeline controller can stall. It is parametrised in operand width, supports signed and unsigned modes, and can be annulled mid-operation when a branch or flush kills the instruction.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- signed_div_i  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- start_i  in  1  request; held high by ex until ready_o is seen.
- annul_i  in  1  abort the current divide.
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready_o  out  1  result valid; registered.

## Operation
- FSM states: FREE, BYZERO, ON, END.
- Reset: state FREE, cnt 0, result_o 0, ready_o 0.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 → BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 → ON. Latch |opdata1|, |opdata2| (absolute values only if signed_div_i=1), both sign bits, and the mode. Clear the partial remainder and cnt.
  - Otherwise stay in FREE with result_o=0 and ready_o=0.
- BYZERO:
  - annul_i=1 → FREE.
  - Else → END with result 0.
- ON, cnt<WIDTH:
  - Shift {rem, dividend} left 1.
  - Trial-subtract the divisor from the WIDTH+1-bit remainder.
  - If non-negative, keep the difference and set quotient bit 1; else quotient bit 0.
  - cnt+1.
- ON, cnt==WIDTH: apply the sign fix, then → END.
  - Signed mode, operand signs differ: negate the quotient.
  - Signed mode, dividend negative: negate the remainder.
- ON, annul_i=1 at any cnt → FREE. No result, ready_o stays 0. Annul has priority over the iteration step.
- END:
  - ready_o=1, result_o holds the value.
  - start_i=1 → stay in END.
  - start_i=0 → FREE; ready_o and result_o return to 0 on the next cycle.
  - annul_i is ignored in END.
- Arithmetic rules:
  - abs(INT_MIN) is taken as unsigned 2^(W-1).
  - INT_MIN/−1 yields quotient INT_MIN, remainder 0; no trap.
- Changes to the operand inputs after they are latched are ignored.

## Timing
- start_i sampled high in FREE on edge N:
  - Iterations run in cycles N+1 through N+WIDTH.
  - Sign fix in cycle N+WIDTH+1.
  - ready_o=1 from cycle N+WIDTH+2 (34 cycles for WIDTH=32).
- Divisor 0: ready_o=1 at cycle N+2 with result_o=0.
- ex deasserts start_i in the cycle it sees ready_o. The unit is back in FREE one cycle later and can accept a new start the following cycle.
- rst=1 in any state → FREE with all outputs 0 on the next edge. A divide in progress is lost.
- rst and start_i high in the same cycle: rst wins.

## Structure
- Shared constants in defines.v:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2 bits);
  - DivResultReady/NotReady;
  - DivStart/DivStop.
- The existing ALU op set gains DIV/DIVU op codes.
- No sub-module: the iteration datapath is a single subtract-and-shift inline.
- openmips top-level changes:
  - instantiate div_unit between ex and ex_mem;
  - route clk/rst;
  - drive annul_i from the flush/branch signal.

## Test plan
- Unsigned 100/7 (WIDTH=32, start at edge N) → ready_o first high at cycle N+34, result_o={0x00000002, 0x0000000E}.
- Signed −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0; unsigned same operands → quotient 0, remainder 0x80000000.
- Divisor 0 (dividend 0x1234) → ready_o at N+2, result_o=0. Start held 5 more cycles → ready_o stays 1. Start dropped → ready_o 0 next cycle.
- annul_i pulsed at cycle N+10 → ready_o never rises, state FREE at N+11. New start at N+12 (unsigned 9/3) → ready_o at N+46 with quotient 3, remainder 0.
- rst at cycle N+20 mid-divide → outputs 0 at N+21. No stale ready_o appears; the next divide completes with the correct result.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
package div_unit_pkg;

    // Divider controller states
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    // Execute stage side: issues requests, consumes results
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one shift-and-subtract step per cycle,
// producing {remainder, quotient} WIDTH+2 cycles after the request is taken.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e          state;
    logic [CNT_W-1:0]    cnt;

    // Datapath registers: partial remainder, dividend shifting into quotient,
    // divisor magnitude and the sign corrections to apply at the end.
    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    dvd_q;
    logic [WIDTH-1:0]    dvs_q;
    logic                neg_quot_q;
    logic                neg_rem_q;
    logic [2*WIDTH-1:0]  res_q;

    logic signed [WIDTH-1:0] op1_s;
    logic signed [WIDTH-1:0] op2_s;
    logic                    op1_neg;
    logic                    op2_neg;

    logic [WIDTH:0]      rem_sh;
    logic [WIDTH:0]      trial;
    logic                trial_ok;
    logic [WIDTH-1:0]    rem_next;

    // Two's-complement negate when requested; -INT_MIN wraps to the
    // unsigned magnitude 2^(WIDTH-1), which is exactly what the core needs.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic            neg);
        return neg ? -v : v;
    endfunction

    // Operand sign detection, only meaningful in signed mode
    always_comb begin
        op1_s   = bus.opdata1_i;
        op2_s   = bus.opdata2_i;
        op1_neg = bus.signed_div_i & (op1_s < 0);
        op2_neg = bus.signed_div_i & (op2_s < 0);
    end

    // One restoring step: shift in the next dividend bit, trial-subtract
    // the divisor, keep the difference only if it did not go negative.
    always_comb begin
        rem_sh   = {rem_q, dvd_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        trial_ok = ~trial[WIDTH];
        rem_next = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

    // Controller and iteration registers; outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DIV_FREE;
            cnt          <= '0;
            bus.result_o <= '0;
            bus.ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    bus.result_o <= '0;
                    bus.ready_o  <= DIV_RESULT_NOT_READY;
                    if (bus.start_i == DIV_START && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state      <= DIV_ON;
                            cnt        <= '0;
                            rem_q      <= '0;
                            dvd_q      <= cond_neg(bus.opdata1_i, op1_neg);
                            dvs_q      <= cond_neg(bus.opdata2_i, op2_neg);
                            neg_quot_q <= op1_neg ^ op2_neg;
                            neg_rem_q  <= op1_neg;
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (bus.annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        res_q <= '0;
                        state <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (bus.annul_i) begin
                        state <= DIV_FREE;
                    end else if (cnt != CNT_LAST) begin
                        rem_q <= rem_next;
                        dvd_q <= {dvd_q[WIDTH-2:0], trial_ok};
                        cnt   <= cnt + CNT_ONE;
                    end else begin
                        res_q <= {cond_neg(rem_q, neg_rem_q),
                                  cond_neg(dvd_q, neg_quot_q)};
                        cnt   <= '0;
                        state <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (bus.start_i == DIV_START) begin
                        bus.result_o <= res_q;
                        bus.ready_o  <= DIV_RESULT_READY;
                    end else begin
                        bus.result_o <= '0;
                        bus.ready_o  <= DIV_RESULT_NOT_READY;
                        state        <= DIV_FREE;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a cycle-level expectation of ready/result is
// derived from plain integer division and the documented latencies, and
// compared against the DUT on every falling edge.
module tb_div_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    // Expected-behaviour state for the transaction in flight
    logic        busy    = 1'b0;
    int          rdy_cyc = 0;
    int          drop_cyc = 0;
    logic [63:0] exp_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: truncating division, remainder takes dividend sign
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Per-cycle comparison against the expected outputs
    always @(negedge clk) begin
        logic exp_rdy;
        if (cyc >= 1) begin
            exp_rdy = busy && (cyc >= rdy_cyc) && (cyc < drop_cyc);
            chk("ready_o", {63'd0, bus.ready_o}, {63'd0, exp_rdy});
            chk("result_o", bus.result_o, exp_rdy ? exp_res : 64'd0);
        end
    end

    // One full divide as ex would issue it; operands are scrambled after the
    // request is taken, annul is held high while the result is being held,
    // and the request ends either by dropping start or by a reset.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int hold, input logic rst_end, input logic [63:0] lit);
        int n;
        @(posedge clk); #1;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        n        = cyc + 1;
        exp_res  = model(a, b, sgn);
        rdy_cyc  = n + ((b == 32'd0) ? 2 : W + 2);
        drop_cyc = 1 << 30;
        busy     = 1'b1;
        chk("model_pin", exp_res, lit);
        @(posedge clk); #1;
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b ^ 32'h0000_5a5a;
        bus.signed_div_i = ~sgn;
        while (cyc < rdy_cyc) begin
            @(posedge clk); #1;
        end
        chk("first_ready", {63'd0, bus.ready_o}, 64'd1);
        chk("result_lit", bus.result_o, lit);
        if (hold > 0) bus.annul_i = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        chk("held_ready", {63'd0, bus.ready_o}, 64'd1);
        bus.annul_i = 1'b0;
        if (rst_end) rst = 1'b1;
        else bus.start_i = 1'b0;
        drop_cyc = cyc + 1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.start_i = 1'b0;
        busy        = 1'b0;
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;

        run_div(32'd100,        32'd7,        1'b0, 0, 1'b0, 64'h00000002_0000000E);
        run_div(32'hFFFFFFF9,   32'd2,        1'b1, 0, 1'b0, 64'hFFFFFFFF_FFFFFFFD);
        run_div(32'd7,          32'hFFFFFFFE, 1'b1, 0, 1'b0, 64'h00000001_FFFFFFFD);
        run_div(32'h80000000,   32'hFFFFFFFF, 1'b1, 0, 1'b0, 64'h00000000_80000000);
        run_div(32'h80000000,   32'hFFFFFFFF, 1'b0, 0, 1'b0, 64'h80000000_00000000);
        run_div(32'h00001234,   32'd0,        1'b0, 5, 1'b0, 64'd0);
        run_div(32'hFFFFFF9C,   32'hFFFFFFF9, 1'b1, 2, 1'b1, 64'hFFFFFFFE_0000000E);
        run_div(32'hFFFFFFFF,   32'd1,        1'b0, 1, 1'b0, 64'h00000000_FFFFFFFF);
        run_div(32'hFFFFFF9C,   32'd0,        1'b1, 0, 1'b0, 64'd0);

        // Annul mid-divide: no result, unit free again for the next request
        @(posedge clk); #1;
        bus.opdata1_i    = 32'd5000;
        bus.opdata2_i    = 32'd3;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        n        = cyc + 1;
        exp_res  = model(32'd5000, 32'd3, 1'b0);
        rdy_cyc  = n + W + 2;
        drop_cyc = 1 << 30;
        busy     = 1'b1;
        while (cyc < n + 9) begin
            @(posedge clk); #1;
        end
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        drop_cyc    = cyc + 1;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        busy        = 1'b0;
        run_div(32'd9, 32'd3, 1'b0, 0, 1'b0, 64'h00000000_00000003);

        // Reset mid-divide with start still high: the divide is lost
        @(posedge clk); #1;
        bus.opdata1_i    = 32'd77777;
        bus.opdata2_i    = 32'd11;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        n        = cyc + 1;
        exp_res  = model(32'd77777, 32'd11, 1'b0);
        rdy_cyc  = n + W + 2;
        drop_cyc = 1 << 30;
        busy     = 1'b1;
        while (cyc < n + 19) begin
            @(posedge clk); #1;
        end
        rst      = 1'b1;
        drop_cyc = cyc + 1;
        @(posedge clk); #1;
        chk("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_mid_result", bus.result_o, 64'd0);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        busy        = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        run_div(32'd1000, 32'd33, 1'b0, 0, 1'b0, 64'h0000000A_0000001E);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
